garegga_sndcmd_tx: RTL and testbench
====================================

Name: garegga_sndcmd_tx

Overview:
- Main-CPU-side transmitter for the 68k→Z80 sound-command mailbox: the sending end of the SOUNDLATCH / Z80INT / WAIT handshake into the sound subsystem.
- Buffers 68k command writes in a small FIFO and presents them one at a time on SOUNDLATCH.
- Raises a Z80INT edge for each command, then waits for the sound side to raise and clear WAIT before sending the next.
- Sits between the 68k bus decoder and the sound block, in the CLK96 domain.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- INT_HOLD, 8, CLK96 cycles Z80INT is held high per command.
- TIMEOUT, 65535, CLK96 cycles allowed in any wait state before the command is abandoned.

Ports:
- CLK96  input  1  sole clock.
- RESET96_N  input  1  asynchronous, active-low reset.
- CMD_WR  input  1  one-cycle 68k write strobe for a sound command.
- CMD_DIN  input  8  command byte, sampled when CMD_WR=1.
- CLR_ERR  input  1  one-cycle strobe clearing the OVERRUN and TMO flags.
- WAIT  input  1  sound-side handshake flag: set by the Z80INT edge, cleared by the Z80 ack.
- SOUNDLATCH  output  8  current command byte.
- Z80INT  output  1  interrupt request; the sound side triggers on its rising edge.
- BUSY  output  1  high when a transfer is in progress or the FIFO is non-empty.
- FULL  output  1  FIFO full.
- LEVEL  output  5  FIFO occupancy, 0..DEPTH.
- OVERRUN  output  1  sticky: a write arrived while full.
- TMO  output  1  sticky: a transfer timed out.

Behaviour:
- Reset (asynchronous, RESET96_N=0): all of the following are forced immediately, independent of CLK96.
  - SOUNDLATCH=0, Z80INT=0, BUSY=0, FULL=0, LEVEL=0, OVERRUN=0, TMO=0.
  - FIFO pointers zeroed; state=IDLE; hold and timeout counters zeroed.
  - Asserting reset mid-transfer drops Z80INT at once and discards all queued commands.
- FIFO:
  - CMD_WR with FULL=0 pushes CMD_DIN; LEVEL increments on the next edge.
  - CMD_WR with FULL=1 leaves the FIFO unchanged and sets OVERRUN.
  - A push and a pop in the same cycle leave LEVEL unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - FULL = (LEVEL==DEPTH).
- State machine, one transition per CLK96 edge:
  - IDLE: if LEVEL>0, pop the head into SOUNDLATCH and go to ASSERT. A write into an empty FIFO therefore reaches SOUNDLATCH 2 cycles after CMD_WR.
  - ASSERT: Z80INT=1 for exactly INT_HOLD cycles, then Z80INT=0 and go to SYNC. SOUNDLATCH is stable from load until the next pop.
  - SYNC: wait for WAIT=1, then go to ACK. If WAIT was already 1 on entry, advance on the first cycle.
  - ACK: wait for WAIT=0, then go to GAP.
  - GAP: one cycle with Z80INT=0, guaranteeing a low interval before the next rising edge; then go to IDLE.
  - Timeout: a counter restarts on entry to SYNC and to ACK. Reaching TIMEOUT sets TMO and forces GAP; the popped command counts as sent and is not retried.
- Flags:
  - BUSY = (state != IDLE) or (LEVEL > 0).
  - CLR_ERR clears OVERRUN and TMO. If a new error occurs in the same cycle as CLR_ERR, the set wins.
- WAIT is asynchronous to the command flow but already in the CLK96 domain; it is used directly, with no synchronizer.
- Only the sending state machine ever drives SOUNDLATCH; CMD_WR never bypasses the FIFO.

Test Plan:
1. Reset release; CMD_WR with 0x5A; sound model raises WAIT 3 cycles after the Z80INT edge and clears it 20 cycles later → SOUNDLATCH=0x5A 2 cycles after CMD_WR; Z80INT high for 8 cycles; BUSY=0 two cycles after WAIT falls.
2. Four back-to-back writes 0x01..0x04 with DEPTH=4 → LEVEL reaches 3 (the first entry is popped immediately); exactly one Z80INT rising edge per command; the sound side receives the commands in order; Z80INT is low for at least 1 cycle between pulses.
3. Six writes with WAIT held 0 → FULL=1; OVERRUN=1 after the fifth or sixth write; LEVEL stays at 4; the dropped bytes are never transmitted.
4. WAIT never rises, TIMEOUT=100 → TMO=1 exactly 100 cycles after entering SYNC; the next queued byte is then sent; CLR_ERR clears TMO one cycle later.
5. RESET96_N pulsed low during ASSERT with 2 entries queued → Z80INT=0 and LEVEL=0 immediately, before the next edge; no further interrupts after release.
6. CLR_ERR in the same cycle as an overrun write → OVERRUN remains 1.

Source files
------------

// File: rtl/garegga_sndcmd_tx.sv
// rtl/garegga_sndcmd_tx.sv - 68k-side sound-command mailbox transmitter (FIFO + Z80INT/WAIT handshake)
//
// Purpose:
//   Queues 68k sound-command writes in a small FIFO and hands them to the
//   sound subsystem one at a time. Each command is placed on SOUNDLATCH, a
//   Z80INT pulse of INT_HOLD cycles is raised, and the transmitter then waits
//   for the sound side to raise and clear WAIT. A single low cycle (GAP)
//   always separates consecutive Z80INT pulses. A stuck handshake is
//   abandoned after TIMEOUT cycles in SYNC or ACK and flagged on TMO.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, 2..16)
//   INT_HOLD  cycles Z80INT stays high per command
//   TIMEOUT   cycles allowed in SYNC or ACK before the command is abandoned
//
// Ports:
//   CLK96       in   1  clock
//   RESET96_N   in   1  asynchronous active-low reset
//   CMD_WR      in   1  command write strobe
//   CMD_DIN     in   8  command byte
//   CLR_ERR     in   1  clears OVERRUN and TMO (a same-cycle set wins)
//   WAIT        in   1  sound-side handshake flag (already in CLK96 domain)
//   SOUNDLATCH  out  8  command byte presented to the sound side
//   Z80INT      out  1  interrupt request, rising-edge significant
//   BUSY        out  1  transfer in progress or FIFO non-empty
//   FULL        out  1  FIFO full
//   LEVEL       out  5  FIFO occupancy
//   OVERRUN     out  1  sticky: write while full
//   TMO         out  1  sticky: handshake timed out

module garegga_sndcmd_tx #(
    parameter int DEPTH    = 4,
    parameter int INT_HOLD = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic       CLK96,
    input  logic       RESET96_N,
    input  logic       CMD_WR,
    input  logic [7:0] CMD_DIN,
    input  logic       CLR_ERR,
    input  logic       WAIT,
    output logic [7:0] SOUNDLATCH,
    output logic       Z80INT,
    output logic       BUSY,
    output logic       FULL,
    output logic [4:0] LEVEL,
    output logic       OVERRUN,
    output logic       TMO
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(INT_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ASSERT = 3'd1,
        S_SYNC   = 3'd2,
        S_ACK    = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [4:0]      r_level;
    logic [7:0]      r_latch;
    logic [HW-1:0]   r_hold;
    logic [TW-1:0]   r_tcnt;
    logic            r_ovr;
    logic            r_tmo;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_ovr_set;
    logic            w_tmo_set;
    logic            w_hold_done;
    logic            w_tmo_hit;
    logic            w_hold_run;
    logic            w_tcnt_run;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_full      = (r_level == 5'(DEPTH));
        w_push      = CMD_WR && !w_full;
        w_ovr_set   = CMD_WR && w_full;
        w_hold_done = (r_hold == HW'(INT_HOLD - 1));
        w_tmo_hit   = (r_tcnt == TW'(TIMEOUT - 1));
        w_pop       = 1'b0;
        w_tmo_set   = 1'b0;
        w_next      = r_state;

        case (r_state)
            S_IDLE: begin
                if (r_level != 5'd0) begin
                    w_pop  = 1'b1;
                    w_next = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (w_hold_done) begin
                    w_next = S_SYNC;
                end
            end
            S_SYNC: begin
                // WAIT wins over an expiring timeout on the same cycle.
                if (WAIT) begin
                    w_next = S_ACK;
                end else if (w_tmo_hit) begin
                    w_tmo_set = 1'b1;
                    w_next    = S_GAP;
                end
            end
            S_ACK: begin
                if (!WAIT) begin
                    w_next = S_GAP;
                end else if (w_tmo_hit) begin
                    w_tmo_set = 1'b1;
                    w_next    = S_GAP;
                end
            end
            S_GAP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Counters run only while staying in their state; any transition
        // (including SYNC -> ACK) restarts them from zero.
        w_hold_run = (r_state == S_ASSERT) && (w_next == S_ASSERT);
        w_tcnt_run = ((r_state == S_SYNC) || (r_state == S_ACK)) && (w_next == r_state);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Hold and timeout counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            r_hold <= '0;
            r_tcnt <= '0;
        end else begin
            r_hold <= w_hold_run ? (r_hold + HW'(1)) : '0;
            r_tcnt <= w_tcnt_run ? (r_tcnt + TW'(1)) : '0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents need no reset; pointers and level do)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96) begin
        if (w_push) begin
            r_mem[r_wptr] <= CMD_DIN;
        end
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= 5'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command latch: loaded only by the sending FSM on a pop
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            r_latch <= 8'h00;
        end else if (w_pop) begin
            r_latch <= r_mem[r_rptr];
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: set has priority over CLR_ERR
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            r_ovr <= 1'b0;
            r_tmo <= 1'b0;
        end else begin
            r_ovr <= w_ovr_set || (r_ovr && !CLR_ERR);
            r_tmo <= w_tmo_set || (r_tmo && !CLR_ERR);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers so reset reaches them at once
    // ------------------------------------------------------------------
    assign SOUNDLATCH = r_latch;
    assign Z80INT     = (r_state == S_ASSERT);
    assign BUSY       = (r_state != S_IDLE) || (r_level != 5'd0);
    assign FULL       = w_full;
    assign LEVEL      = r_level;
    assign OVERRUN    = r_ovr;
    assign TMO        = r_tmo;

endmodule

// File: tb/tb_garegga_sndcmd_tx.sv
// tb/tb_garegga_sndcmd_tx.sv - directed self-checking bench for garegga_sndcmd_tx

module tb_garegga_sndcmd_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_din = 8'h00;
    logic       clr_err = 1'b0;
    logic       snd_wait = 1'b0;
    logic [7:0] soundlatch;
    logic       z80int;
    logic       busy;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       tmo;

    int n_checks = 0;
    int n_errors = 0;

    garegga_sndcmd_tx #(
        .DEPTH    (4),
        .INT_HOLD (8),
        .TIMEOUT  (100)
    ) dut (
        .CLK96      (clk),
        .RESET96_N  (rst_n),
        .CMD_WR     (cmd_wr),
        .CMD_DIN    (cmd_din),
        .CLR_ERR    (clr_err),
        .WAIT       (snd_wait),
        .SOUNDLATCH (soundlatch),
        .Z80INT     (z80int),
        .BUSY       (busy),
        .FULL       (full),
        .LEVEL      (level),
        .OVERRUN    (overrun),
        .TMO        (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cmd(input logic [7:0] b);
        cmd_wr  = 1'b1;
        cmd_din = b;
        tick();
        cmd_wr  = 1'b0;
    endtask

    // Sound-side model: wait for Z80INT high, capture SOUNDLATCH, raise WAIT
    // raise_dly cycles after the first high sample and drop it hold cycles later.
    task automatic serve(input int raise_dly, input int hold,
                         output logic [7:0] rx, output int hi, output int lo);
        lo = 0;
        hi = 0;
        for (int i = 0; i < 200 && !z80int; i++) begin
            lo++;
            tick();
        end
        check("serve_irq", 32'(z80int), 32'd1);
        rx = soundlatch;
        for (int c = 0; c <= raise_dly + hold; c++) begin
            hi += int'(z80int);
            if (c == raise_dly)        snd_wait = 1'b1;
            if (c == raise_dly + hold) snd_wait = 1'b0;
            tick();
        end
    endtask

    task automatic count_highs(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            n += int'(z80int);
            tick();
        end
    endtask

    initial begin
        logic [7:0] rx;
        int         hi;
        int         lo;
        int         nh;
        int         maxlev;

        // ---------------- reset state ----------------
        #2;
        check("rst_latch", 32'(soundlatch), 32'h00);
        check("rst_int",   32'(z80int),     32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_full",  32'(full),       32'd0);
        check("rst_level", 32'(level),      32'd0);
        check("rst_ovr",   32'(overrun),    32'd0);
        check("rst_tmo",   32'(tmo),        32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- test 1: single command ----------------
        write_cmd(8'h5A);
        check("t1_level1",   32'(level),      32'd1);
        check("t1_latch_e1", 32'(soundlatch), 32'h00);
        check("t1_busy",     32'(busy),       32'd1);
        tick();
        check("t1_latch_e2", 32'(soundlatch), 32'h5A);
        check("t1_int_e2",   32'(z80int),     32'd1);
        serve(3, 20, rx, hi, lo);
        check("t1_rx",      32'(rx), 32'h5A);
        check("t1_int_len", 32'(hi), 32'd8);
        check("t1_busy_w1", 32'(busy), 32'd1);
        tick();
        check("t1_busy_w2", 32'(busy), 32'd0);

        // ---------------- test 2: four back-to-back writes ----------------
        maxlev = 0;
        for (int k = 0; k < 4; k++) begin
            write_cmd(8'(k + 1));
            if (int'(level) > maxlev) maxlev = int'(level);
        end
        check("t2_level", 32'(level), 32'd3);
        check("t2_maxlev", 32'(maxlev), 32'd3);
        for (int k = 0; k < 4; k++) begin
            serve(3, 20, rx, hi, lo);
            check("t2_rx", 32'(rx), 32'(k + 1));
            // First pulse started two samples before the model attached.
            check("t2_int_len", 32'(hi), (k == 0) ? 32'd6 : 32'd8);
            if (k > 0) check("t2_low_gap", 32'(lo >= 1), 32'd1);
        end
        count_highs(40, nh);
        check("t2_no_extra", 32'(nh), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);

        // ---------------- test 3 + 6: overflow, overrun, clear-vs-set ----------------
        for (int k = 0; k < 5; k++) write_cmd(8'hA1 + 8'(k));
        check("t3_full",   32'(full),    32'd1);
        check("t3_level4", 32'(level),   32'd4);
        check("t3_ovr0",   32'(overrun), 32'd0);
        write_cmd(8'hA6);
        check("t3_ovr1",   32'(overrun), 32'd1);
        check("t3_level_k", 32'(level),  32'd4);
        check("t3_full_k", 32'(full),    32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_ovr_clr", 32'(overrun), 32'd0);
        cmd_wr  = 1'b1;
        cmd_din = 8'hA7;
        clr_err = 1'b1;
        tick();
        cmd_wr  = 1'b0;
        clr_err = 1'b0;
        check("t6_set_wins", 32'(overrun), 32'd1);
        check("t6_level",    32'(level),   32'd4);
        for (int k = 0; k < 5; k++) begin
            serve(3, 20, rx, hi, lo);
            check("t3_rx", 32'(rx), 32'hA1 + 32'(k));
        end
        count_highs(40, nh);
        check("t3_no_drop_tx", 32'(nh), 32'd0);
        check("t3_level0", 32'(level), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_ovr_clr2", 32'(overrun), 32'd0);

        // ---------------- test 4: timeout ----------------
        write_cmd(8'hB1);
        write_cmd(8'hB2);
        for (int i = 0; i < 50 && z80int; i++) tick();
        check("t4_sync_entry", 32'(z80int), 32'd0);
        repeat (99) tick();
        check("t4_tmo_99",  32'(tmo), 32'd0);
        tick();
        check("t4_tmo_100", 32'(tmo), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_tmo_clr", 32'(tmo), 32'd0);
        tick();
        check("t4_next_latch", 32'(soundlatch), 32'hB2);
        check("t4_next_int",   32'(z80int),     32'd1);
        serve(3, 20, rx, hi, lo);
        check("t4_rx", 32'(rx), 32'hB2);
        tick();
        check("t4_idle", 32'(busy), 32'd0);

        // ---------------- test 5: reset mid-ASSERT ----------------
        write_cmd(8'hC1);
        write_cmd(8'hC2);
        write_cmd(8'hC3);
        check("t5_level_pre", 32'(level),  32'd2);
        check("t5_int_pre",   32'(z80int), 32'd1);
        rst_n = 1'b0;
        #2;
        check("t5_int_async",   32'(z80int),     32'd0);
        check("t5_level_async", 32'(level),      32'd0);
        check("t5_busy_async",  32'(busy),       32'd0);
        check("t5_latch_async", 32'(soundlatch), 32'h00);
        #2;
        rst_n = 1'b1;
        tick();
        count_highs(40, nh);
        check("t5_no_int", 32'(nh), 32'd0);
        check("t5_level",  32'(level), 32'd0);
        check("t5_busy",   32'(busy),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
